// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, MEM-stage data port and external memory bus around mem_arbiter.
// Optional macro ARB_TIMEOUT_EN adds the sticky bus_err signal.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              inst_req;
   logic [ADDR_W-1:0] inst_addr;
   logic [DATA_W-1:0] inst_rdata;
   logic              inst_stall;
   logic              data_req;
   logic              data_we;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic [DATA_W-1:0] data_rdata;
   logic              data_stall;
   logic              stall_all;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
`ifdef ARB_TIMEOUT_EN
   logic              bus_err;
`endif

   // Arbiter side
   modport slave (
      input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata,
      input  mem_rdata, mem_ready,
      output inst_rdata, inst_stall, data_rdata, data_stall, stall_all,
      output mem_req, mem_we, mem_addr, mem_wdata
`ifdef ARB_TIMEOUT_EN
      , output bus_err
`endif
   );

   // Core + memory side
   modport master (
      output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata,
      output mem_rdata, mem_ready,
      input  inst_rdata, inst_stall, data_rdata, data_stall, stall_all,
      input  mem_req, mem_we, mem_addr, mem_wdata
`ifdef ARB_TIMEOUT_EN
      , input bus_err
`endif
   );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto one single-port memory, data first, with pipeline stalls.
// Optional macro ARB_TIMEOUT_EN adds a BUSY watchdog that aborts with 32'hDEADBEEF and sets bus_err.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_e;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mem_arbiter: TIMEOUT must be at least 1");
   end

   state_e            state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
   logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
   logic              inst_hit_q, inst_hit_d;
   logic              data_hit_q, data_hit_d;
   logic              inst_stall, data_stall, stall_all;
   logic              inst_set, data_set;
   logic              busy, abort, finish;

   assign inst_stall = bus.inst_req & ~inst_hit_q;
   assign data_stall = bus.data_req & ~data_hit_q;
   assign stall_all  = inst_stall | data_stall;
   assign busy       = (state_q != IDLE);

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             bus_err_q, bus_err_d;

   // The abort edge is the one that would bring the count up to TIMEOUT.
   assign abort = busy & ~bus.mem_ready & (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      bus_err_d = bus_err_q | abort;
      if (!busy) begin
         tmo_cnt_d = '0;
      end else if (!bus.mem_ready) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         bus_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign bus.bus_err = bus_err_q;
`else
   assign abort = 1'b0;
`endif

   assign finish = busy & (bus.mem_ready | abort);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (data_stall) begin
               state_d = BUSY_D;
            end else if (inst_stall) begin
               state_d = BUSY_I;
            end
         end
         BUSY_D, BUSY_I: begin
            if (finish) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      inst_set     = 1'b0;
      data_set     = 1'b0;
      case (state_q)
         IDLE: begin
            if (data_stall) begin
               mem_req_d   = 1'b1;
               mem_we_d    = bus.data_we;
               mem_addr_d  = bus.data_addr;
               mem_wdata_d = bus.data_wdata;
            end else if (inst_stall) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = bus.inst_addr;
            end
         end
         BUSY_D: begin
            if (finish) begin
               if (abort) begin
                  data_rdata_d = DATA_W'(32'hDEADBEEF);
               end else if (!mem_we_q) begin
                  data_rdata_d = bus.mem_rdata;
               end
               data_set  = 1'b1;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         BUSY_I: begin
            if (finish) begin
               inst_rdata_d = abort ? DATA_W'(32'hDEADBEEF) : bus.mem_rdata;
               inst_set     = 1'b1;
               mem_req_d    = 1'b0;
               mem_we_d     = 1'b0;
            end
         end
         default: ;
      endcase
      // A pipeline advance clears both hits and takes precedence over a set.
      inst_hit_d = stall_all ? (inst_hit_q | inst_set) : 1'b0;
      data_hit_d = stall_all ? (data_hit_q | data_set) : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
         inst_hit_q   <= 1'b0;
         data_hit_q   <= 1'b0;
      end else begin
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
         inst_hit_q   <= inst_hit_d;
         data_hit_q   <= data_hit_d;
      end
   end

   assign bus.inst_stall = inst_stall;
   assign bus.data_stall = data_stall;
   assign bus.stall_all  = stall_all;
   assign bus.inst_rdata = inst_rdata_q;
   assign bus.data_rdata = data_rdata_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory responder with a scoreboard of expected issues,
// plus per-scenario tasks for stalls, read data and reset behaviour.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   txn_t        exp_q[$];
   logic [31:0] mem[int unsigned];
   int          vectors = 0;
   int          miscompares = 0;
   int          wait_cycles = 0;
   logic        no_ready = 1'b0;
   int          wcnt = 0;
   logic        prev_req = 1'b0;

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   // Memory responder and issue scoreboard, both on the falling edge
   always @(negedge clk) begin
      if (ifc.mem_req && !prev_req) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL issue_unexpected: got addr=%h we=%b, required no issue", ifc.mem_addr, ifc.mem_we);
         end else begin
            txn_t t;
            t = exp_q.pop_front();
            if (ifc.mem_addr !== t.addr || ifc.mem_we !== t.we || (t.we && ifc.mem_wdata !== t.wdata)) begin
               miscompares++;
               $display("FAIL issue_order: got addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                        ifc.mem_addr, ifc.mem_we, ifc.mem_wdata, t.addr, t.we, t.wdata);
            end
         end
      end
      prev_req = ifc.mem_req;
      if (rst || !ifc.mem_req) begin
         wcnt = 0;
         ifc.mem_ready = 1'b0;
         ifc.mem_rdata = $urandom;
      end else begin
         ifc.mem_ready = !no_ready && (wcnt == wait_cycles);
         if (ifc.mem_ready) begin
            if (ifc.mem_we) mem[ifc.mem_addr] = ifc.mem_wdata;
            else            ifc.mem_rdata = rd(ifc.mem_addr);
         end else begin
            ifc.mem_rdata = $urandom;
         end
         wcnt++;
      end
   end

   task automatic idle_inputs();
      ifc.inst_req   = 1'b0;
      ifc.data_req   = 1'b0;
      ifc.data_we    = 1'b0;
      ifc.inst_addr  = '0;
      ifc.data_addr  = '0;
      ifc.data_wdata = '0;
   endtask

   // Counts stall_all cycles from now until the pipeline may advance, with bounded wait
   task automatic wait_free(output int n_stall, output int n_req, output int n_we);
      n_stall = 0; n_req = 0; n_we = 0;
      while (ifc.stall_all && n_stall < 300) begin
         n_stall++;
         if (ifc.mem_req) n_req++;
         if (ifc.mem_req && ifc.mem_we) n_we++;
         @(negedge clk); #1;
      end
      if (n_stall >= 300) begin
         vectors++; miscompares++;
         $display("FAIL wait_free_timeout: stall_all still %b after %0d cycles, required 0", ifc.stall_all, n_stall);
      end
   endtask

   task automatic release_port();
      @(negedge clk);
      idle_inputs();
      @(negedge clk); @(negedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      ifc.mem_ready = 1'b0;
      ifc.mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (ifc.mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req: got %b, required 0", ifc.mem_req); end
      vectors++; if (ifc.mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we: got %b, required 0", ifc.mem_we); end
      vectors++; if (ifc.mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr: got %h, required 0", ifc.mem_addr); end
      vectors++; if (ifc.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_wdata: got %h, required 0", ifc.mem_wdata); end
      vectors++; if (ifc.inst_rdata !== 32'h0 || ifc.data_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h/%h, required 0/0", ifc.inst_rdata, ifc.data_rdata); end
      vectors++; if (ifc.stall_all !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %b, required 0", ifc.stall_all); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic test_fetch();
      int ns, nr, nw;
      mem[32'h0]  = 32'h20080005;
      wait_cycles = 0;
      exp_q.push_back('{1'b0, 32'h0, 32'h0});
      ifc.inst_req  = 1'b1;
      ifc.inst_addr = 32'h0;
      #1;
      wait_free(ns, nr, nw);
      vectors++; if (ns !== 2) begin miscompares++; $display("FAIL fetch_stall_cycles: got %0d, required 2", ns); end
      vectors++; if (nr !== 1) begin miscompares++; $display("FAIL fetch_req_cycles: got %0d, required 1", nr); end
      vectors++; if (ifc.inst_rdata !== 32'h20080005) begin miscompares++; $display("FAIL fetch_rdata: got %h, required 20080005", ifc.inst_rdata); end
      // Request still held across the advance edge: hit must have cleared
      @(posedge clk); #1;
      vectors++; if (ifc.inst_stall !== 1'b1) begin miscompares++; $display("FAIL fetch_hit_clear: inst_stall got %b, required 1", ifc.inst_stall); end
      vectors++; if (ifc.mem_req !== 1'b0) begin miscompares++; $display("FAIL fetch_no_reissue_yet: mem_req got %b, required 0", ifc.mem_req); end
      release_port();
   endtask

   task automatic test_back_to_back();
      int ns, nr, nw;
      mem[32'h4]  = 32'h11112222;
      mem[32'h40] = 32'h33334444;
      wait_cycles = 0;
      exp_q.push_back('{1'b0, 32'h40, 32'h0});
      exp_q.push_back('{1'b0, 32'h4, 32'h0});
      ifc.inst_req  = 1'b1; ifc.inst_addr = 32'h4;
      ifc.data_req  = 1'b1; ifc.data_we   = 1'b0; ifc.data_addr = 32'h40;
      #1;
      wait_free(ns, nr, nw);
      vectors++; if (ns !== 4) begin miscompares++; $display("FAIL both_stall_cycles: got %0d, required 4", ns); end
      vectors++; if (nr !== 2) begin miscompares++; $display("FAIL both_req_cycles: got %0d, required 2", nr); end
      vectors++; if (ifc.data_rdata !== 32'h33334444) begin miscompares++; $display("FAIL both_data_rdata: got %h, required 33334444", ifc.data_rdata); end
      vectors++; if (ifc.inst_rdata !== 32'h11112222) begin miscompares++; $display("FAIL both_inst_rdata: got %h, required 11112222", ifc.inst_rdata); end
      release_port();
   endtask

   task automatic test_store();
      int ns, nr, nw, nstable;
      wait_cycles = 3;
      exp_q.push_back('{1'b1, 32'h50, 32'hCAFEF00D});
      ifc.data_req = 1'b1; ifc.data_we = 1'b1;
      ifc.data_addr = 32'h50; ifc.data_wdata = 32'hCAFEF00D;
      #1;
      ns = 0; nstable = 0;
      while (ifc.data_stall && ns < 300) begin
         ns++;
         if (ifc.mem_req && ifc.mem_we && ifc.mem_wdata === 32'hCAFEF00D && ifc.mem_addr === 32'h50) nstable++;
         @(negedge clk); #1;
      end
      vectors++; if (ns !== 5) begin miscompares++; $display("FAIL store_stall_cycles: got %0d, required 5", ns); end
      vectors++; if (nstable !== 4) begin miscompares++; $display("FAIL store_we_stable: got %0d, required 4", nstable); end
      vectors++; if (ifc.data_rdata !== 32'h33334444) begin miscompares++; $display("FAIL store_rdata_kept: got %h, required 33334444", ifc.data_rdata); end
      vectors++; if (rd(32'h50) !== 32'hCAFEF00D) begin miscompares++; $display("FAIL store_mem_write: got %h, required cafef00d", rd(32'h50)); end
      release_port();
   endtask

   task automatic test_addr_change();
      int ns, nr, nw;
      mem[32'h60] = 32'h55556666;
      mem[32'h70] = 32'hBADBAD00;
      mem[32'h8]  = 32'h77778888;
      wait_cycles = 1;
      exp_q.push_back('{1'b0, 32'h60, 32'h0});
      exp_q.push_back('{1'b0, 32'h8, 32'h0});
      ifc.inst_req = 1'b1; ifc.inst_addr = 32'h8;
      ifc.data_req = 1'b1; ifc.data_we = 1'b0; ifc.data_addr = 32'h60;
      @(negedge clk); #1;
      ifc.data_addr  = 32'h70;
      ifc.data_wdata = 32'h12345678;
      @(negedge clk); #1;
      vectors++; if (ifc.mem_addr !== 32'h60) begin miscompares++; $display("FAIL chg_mem_addr_held: got %h, required 60", ifc.mem_addr); end
      wait_free(ns, nr, nw);
      vectors++; if (ns !== 4) begin miscompares++; $display("FAIL chg_stall_cycles: got %0d, required 4", ns); end
      vectors++; if (ifc.data_rdata !== 32'h55556666) begin miscompares++; $display("FAIL chg_data_rdata: got %h, required 55556666", ifc.data_rdata); end
      vectors++; if (ifc.inst_rdata !== 32'h77778888) begin miscompares++; $display("FAIL chg_inst_rdata: got %h, required 77778888", ifc.inst_rdata); end
      release_port();
   endtask

   task automatic test_reset_mid();
      int ns, nr, nw;
      mem[32'hC] = 32'h9999AAAA;
      wait_cycles = 5;
      exp_q.push_back('{1'b0, 32'hC, 32'h0});
      ifc.inst_req = 1'b1; ifc.inst_addr = 32'hC;
      @(negedge clk); #1;
      vectors++; if (ifc.mem_req !== 1'b1) begin miscompares++; $display("FAIL rstmid_issued: mem_req got %b, required 1", ifc.mem_req); end
      rst = 1'b1;
      @(posedge clk); #1;
      vectors++; if (ifc.mem_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_mem_req: got %b, required 0", ifc.mem_req); end
      vectors++; if (ifc.inst_rdata !== 32'h0 || ifc.data_rdata !== 32'h0) begin miscompares++; $display("FAIL rstmid_rdata: got %h/%h, required 0/0", ifc.inst_rdata, ifc.data_rdata); end
      vectors++; if (ifc.inst_stall !== 1'b1) begin miscompares++; $display("FAIL rstmid_hit: inst_stall got %b, required 1", ifc.inst_stall); end
      @(negedge clk);
      rst = 1'b0;
      wait_cycles = 0;
      exp_q.push_back('{1'b0, 32'hC, 32'h0});
      #1;
      wait_free(ns, nr, nw);
      vectors++; if (ifc.inst_rdata !== 32'h9999AAAA) begin miscompares++; $display("FAIL rstmid_refetch: got %h, required 9999aaaa", ifc.inst_rdata); end
      release_port();
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      int ns, nr, nw;
      no_ready = 1'b1;
      exp_q.push_back('{1'b0, 32'h90, 32'h0});
      ifc.data_req = 1'b1; ifc.data_we = 1'b0; ifc.data_addr = 32'h90;
      #1;
      wait_free(ns, nr, nw);
      vectors++; if (ns !== 5) begin miscompares++; $display("FAIL tmo_stall_cycles: got %0d, required 5", ns); end
      vectors++; if (ifc.data_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL tmo_rdata: got %h, required deadbeef", ifc.data_rdata); end
      vectors++; if (ifc.mem_req !== 1'b0) begin miscompares++; $display("FAIL tmo_mem_req: got %b, required 0", ifc.mem_req); end
      release_port();
      no_ready = 1'b0;
      vectors++; if (ifc.bus_err !== 1'b1) begin miscompares++; $display("FAIL tmo_bus_err_sticky: got %b, required 1", ifc.bus_err); end
      rst = 1'b1;
      @(posedge clk); #1;
      vectors++; if (ifc.bus_err !== 1'b0) begin miscompares++; $display("FAIL tmo_bus_err_rst: got %b, required 0", ifc.bus_err); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
   endtask
`endif

   initial begin
      test_reset();
      test_fetch();
      test_back_to_back();
      test_store();
      test_addr_change();
      test_reset_mid();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`endif
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending issues, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
